// File: rtl/clock_cmd_decoder_if.sv
// Byte-stream handshake between a host/UART byte source and clock_cmd_decoder.
// A byte transfers on a rising edge where in_valid && in_ready.
interface clock_cmd_decoder_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/clock_cmd_decoder.sv
// Framed byte-command decoder for digital_clock: collects opcode + operands,
// range-checks them and commits them atomically to the registered control outputs.
//
// state   | meaning
// IDLE    | waiting for an opcode byte
// OPERAND | collecting operand bytes, rem = bytes still to come
// COMMIT  | one cycle, in_ready low; validate shadows and update live outputs
module clock_cmd_decoder #(
    parameter int DEFAULT_YEAR = 2020,
    parameter int DEFAULT_MODE = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    clock_cmd_decoder_if.slave   bus,
    input  logic                 alarm_ack,
    input  logic                 timer_done,
    output logic [4:0]           set_hour,
    output logic [5:0]           set_min,
    output logic [5:0]           set_sec,
    output logic [4:0]           set_day,
    output logic [3:0]           set_month,
    output logic [11:0]          set_year,
    output logic                 load_time,
    output logic [4:0]           alarm_hour,
    output logic [5:0]           alarm_min,
    output logic [5:0]           alarm_sec,
    output logic                 alarm_enable,
    output logic [5:0]           timer_min,
    output logic [5:0]           timer_sec,
    output logic                 timer_start,
    output logic [1:0]           display_mode,
    output logic                 cmd_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_OPERAND = 2'd1;
    localparam logic [1:0] S_COMMIT  = 2'd2;

    logic [1:0] state;
    logic [7:0] opcode;
    logic [2:0] rem;
    logic       bad_op;
    logic [7:0] shadow [7];
    logic       accept;
    logic       frame_ok;

    function automatic logic [2:0] op_len(input logic [7:0] op);
        case (op)
            8'd3:    op_len = 3'd7;
            8'd4:    op_len = 3'd3;
            8'd5:    op_len = 3'd2;
            default: op_len = 3'd0;
        endcase
    endfunction

    assign bus.in_ready = (state != S_COMMIT);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        frame_ok = !bad_op;
        case (opcode)
            8'd3: if (shadow[0] > 8'd23 || shadow[1] > 8'd59 || shadow[2] > 8'd59 ||
                      shadow[3] == 8'd0 || shadow[3] > 8'd31 ||
                      shadow[4] == 8'd0 || shadow[4] > 8'd12 || shadow[5] > 8'd15)
                      frame_ok = 1'b0;
            8'd4: if (shadow[0] > 8'd23 || shadow[1] > 8'd59 || shadow[2] > 8'd59)
                      frame_ok = 1'b0;
            8'd5: if (shadow[0] > 8'd59 || shadow[1] > 8'd59 ||
                      (shadow[0] == 8'd0 && shadow[1] == 8'd0))
                      frame_ok = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            opcode       <= 8'd0;
            rem          <= 3'd0;
            bad_op       <= 1'b0;
            for (int i = 0; i < 7; i++) shadow[i] <= 8'd0;
            set_hour     <= 5'd0;
            set_min      <= 6'd0;
            set_sec      <= 6'd0;
            set_day      <= 5'd1;
            set_month    <= 4'd1;
            set_year     <= 12'(DEFAULT_YEAR);
            load_time    <= 1'b0;
            alarm_hour   <= 5'd0;
            alarm_min    <= 6'd0;
            alarm_sec    <= 6'd0;
            alarm_enable <= 1'b0;
            timer_min    <= 6'd0;
            timer_sec    <= 6'd0;
            timer_start  <= 1'b0;
            display_mode <= 2'(DEFAULT_MODE);
            cmd_err      <= 1'b0;
        end else begin
            load_time <= 1'b0;
            cmd_err   <= 1'b0;
            if (alarm_ack)  alarm_enable <= 1'b0;
            if (timer_done) timer_start  <= 1'b0;

            case (state)
                S_IDLE: if (accept) begin
                    opcode <= bus.in_data;
                    bad_op <= (bus.in_data == 8'd0) || (bus.in_data > 8'd5);
                    if (op_len(bus.in_data) != 3'd0) begin
                        rem   <= op_len(bus.in_data);
                        state <= S_OPERAND;
                    end else begin
                        state <= S_COMMIT;
                    end
                end
                S_OPERAND: if (accept) begin
                    shadow[op_len(opcode) - rem] <= bus.in_data;
                    rem <= rem - 3'd1;
                    if (rem == 3'd1) state <= S_COMMIT;
                end
                S_COMMIT: begin
                    state <= S_IDLE;
                    // Later assignments here override the ack/done clears above,
                    // so a fresh commit wins over a coincident clear.
                    if (!frame_ok) begin
                        cmd_err <= 1'b1;
                    end else begin
                        case (opcode)
                            8'd1: display_mode <= 2'd1;
                            8'd2: display_mode <= 2'd2;
                            8'd3: begin
                                set_hour  <= shadow[0][4:0];
                                set_min   <= shadow[1][5:0];
                                set_sec   <= shadow[2][5:0];
                                set_day   <= shadow[3][4:0];
                                set_month <= shadow[4][3:0];
                                set_year  <= {shadow[5][3:0], shadow[6]};
                                load_time <= 1'b1;
                            end
                            8'd4: begin
                                alarm_hour   <= shadow[0][4:0];
                                alarm_min    <= shadow[1][5:0];
                                alarm_sec    <= shadow[2][5:0];
                                alarm_enable <= 1'b1;
                            end
                            8'd5: begin
                                timer_min   <= shadow[0][5:0];
                                timer_sec   <= shadow[1][5:0];
                                timer_start <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_cmd_decoder.sv
// Directed bench for clock_cmd_decoder: inputs change on the falling edge,
// outputs are sampled on the falling edge, expectations are hand-computed.
module tb_clock_cmd_decoder;
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        alarm_ack;
    logic        timer_done;
    logic [4:0]  set_hour;
    logic [5:0]  set_min;
    logic [5:0]  set_sec;
    logic [4:0]  set_day;
    logic [3:0]  set_month;
    logic [11:0] set_year;
    logic        load_time;
    logic [4:0]  alarm_hour;
    logic [5:0]  alarm_min;
    logic [5:0]  alarm_sec;
    logic        alarm_enable;
    logic [5:0]  timer_min;
    logic [5:0]  timer_sec;
    logic        timer_start;
    logic [1:0]  display_mode;
    logic        cmd_err;

    int n_checks = 0;
    int n_fail   = 0;
    bq_t frame;

    clock_cmd_decoder_if bus ();

    clock_cmd_decoder #(.DEFAULT_YEAR(2020), .DEFAULT_MODE(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .alarm_ack    (alarm_ack),
        .timer_done   (timer_done),
        .set_hour     (set_hour),
        .set_min      (set_min),
        .set_sec      (set_sec),
        .set_day      (set_day),
        .set_month    (set_month),
        .set_year     (set_year),
        .load_time    (load_time),
        .alarm_hour   (alarm_hour),
        .alarm_min    (alarm_min),
        .alarm_sec    (alarm_sec),
        .alarm_enable (alarm_enable),
        .timer_min    (timer_min),
        .timer_sec    (timer_sec),
        .timer_start  (timer_start),
        .display_mode (display_mode),
        .cmd_err      (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one byte from a falling edge and hold it until it transfers.
    task automatic send_byte(input logic [7:0] b);
        int tries;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        tries = 0;
        while (!bus.in_ready && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (!bus.in_ready) chk("ready_wait", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
    endtask

    // Returns at the falling edge of the first cycle in which commit results are visible.
    task automatic send_frame(input bq_t q, input logic ack, input logic done);
        foreach (q[i]) send_byte(q[i]);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("ready_commit", 32'(bus.in_ready), 32'd0);
        alarm_ack  = ack;
        timer_done = done;
        @(negedge clk);
        alarm_ack  = 1'b0;
        timer_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        alarm_ack = 1'b0;
        timer_done = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_day", 32'(set_day), 32'd1);
        chk("rst_month", 32'(set_month), 32'd1);
        chk("rst_year", 32'(set_year), 32'd2020);
        chk("rst_mode", 32'(display_mode), 32'd2);
        chk("rst_hour", 32'(set_hour), 32'd0);
        chk("rst_alarm_en", 32'(alarm_enable), 32'd0);
        chk("rst_load", 32'(load_time), 32'd0);

        // Time/date load 13:45:30 15-08-2021
        frame = '{8'd3, 8'd13, 8'd45, 8'd30, 8'd15, 8'd8, 8'h07, 8'hE5};
        send_frame(frame, 1'b0, 1'b0);
        chk("t_hour", 32'(set_hour), 32'd13);
        chk("t_min", 32'(set_min), 32'd45);
        chk("t_sec", 32'(set_sec), 32'd30);
        chk("t_day", 32'(set_day), 32'd15);
        chk("t_month", 32'(set_month), 32'd8);
        chk("t_year", 32'(set_year), 32'd2021);
        chk("t_load_on", 32'(load_time), 32'd1);
        chk("t_err", 32'(cmd_err), 32'd0);
        chk("t_ready_back", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        chk("t_load_off", 32'(load_time), 32'd0);

        // Alarm 06:30:00, then ack clears it
        frame = '{8'd4, 8'd6, 8'd30, 8'd0};
        send_frame(frame, 1'b0, 1'b0);
        chk("a_hour", 32'(alarm_hour), 32'd6);
        chk("a_min", 32'(alarm_min), 32'd30);
        chk("a_sec", 32'(alarm_sec), 32'd0);
        chk("a_en", 32'(alarm_enable), 32'd1);
        alarm_ack = 1'b1;
        @(negedge clk);
        alarm_ack = 1'b0;
        chk("a_ack_clear", 32'(alarm_enable), 32'd0);
        frame = '{8'd4, 8'd6, 8'd30, 8'd0};
        send_frame(frame, 1'b1, 1'b0);
        chk("a_ack_on_commit", 32'(alarm_enable), 32'd1);

        // Timer: zero preset rejected, then 01:10 accepted and cleared by done
        frame = '{8'd5, 8'd0, 8'd0};
        send_frame(frame, 1'b0, 1'b0);
        chk("tz_err", 32'(cmd_err), 32'd1);
        chk("tz_start", 32'(timer_start), 32'd0);
        @(negedge clk);
        chk("tz_err_off", 32'(cmd_err), 32'd0);
        frame = '{8'd5, 8'd1, 8'd10};
        send_frame(frame, 1'b0, 1'b0);
        chk("tm_min", 32'(timer_min), 32'd1);
        chk("tm_sec", 32'(timer_sec), 32'd10);
        chk("tm_start", 32'(timer_start), 32'd1);
        chk("tm_err", 32'(cmd_err), 32'd0);
        timer_done = 1'b1;
        @(negedge clk);
        timer_done = 1'b0;
        chk("tm_done_clear", 32'(timer_start), 32'd0);
        frame = '{8'd5, 8'd2, 8'd0};
        send_frame(frame, 1'b0, 1'b1);
        chk("tm_done_on_commit", 32'(timer_start), 32'd1);
        chk("tm_min2", 32'(timer_min), 32'd2);

        // Hour 24 rejected: live time unchanged, no load pulse
        frame = '{8'd3, 8'd24, 8'd0, 8'd0, 8'd1, 8'd1, 8'h07, 8'hE4};
        send_frame(frame, 1'b0, 1'b0);
        chk("bh_err", 32'(cmd_err), 32'd1);
        chk("bh_hour", 32'(set_hour), 32'd13);
        chk("bh_year", 32'(set_year), 32'd2021);
        chk("bh_load", 32'(load_time), 32'd0);

        // Month 13 and year_hi 16 rejected
        frame = '{8'd3, 8'd1, 8'd0, 8'd0, 8'd1, 8'd13, 8'h07, 8'hE4};
        send_frame(frame, 1'b0, 1'b0);
        chk("bm_err", 32'(cmd_err), 32'd1);
        frame = '{8'd3, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'h10, 8'h00};
        send_frame(frame, 1'b0, 1'b0);
        chk("by_err", 32'(cmd_err), 32'd1);
        chk("by_month", 32'(set_month), 32'd8);

        // Boundary accepted: 23:59:59 31-12-4095
        frame = '{8'd3, 8'd23, 8'd59, 8'd59, 8'd31, 8'd12, 8'h0F, 8'hFF};
        send_frame(frame, 1'b0, 1'b0);
        chk("bd_err", 32'(cmd_err), 32'd0);
        chk("bd_hour", 32'(set_hour), 32'd23);
        chk("bd_day", 32'(set_day), 32'd31);
        chk("bd_year", 32'(set_year), 32'd4095);

        // Unknown opcode
        frame = '{8'd9};
        send_frame(frame, 1'b0, 1'b0);
        chk("op9_err", 32'(cmd_err), 32'd1);
        chk("op9_ready", 32'(bus.in_ready), 32'd1);

        // Display mode
        frame = '{8'd1};
        send_frame(frame, 1'b0, 1'b0);
        chk("mode_12", 32'(display_mode), 32'd1);
        chk("mode_12_err", 32'(cmd_err), 32'd0);
        frame = '{8'd2};
        send_frame(frame, 1'b0, 1'b0);
        chk("mode_24", 32'(display_mode), 32'd2);

        // Reset mid-frame discards the partial alarm frame
        send_byte(8'd4);
        send_byte(8'd7);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mr_alarm_hour", 32'(alarm_hour), 32'd0);
        chk("mr_alarm_en", 32'(alarm_enable), 32'd0);
        chk("mr_err", 32'(cmd_err), 32'd0);
        chk("mr_ready", 32'(bus.in_ready), 32'd1);
        chk("mr_year", 32'(set_year), 32'd2020);
        frame = '{8'd1};
        send_frame(frame, 1'b0, 1'b0);
        chk("mr_opcode", 32'(display_mode), 32'd1);
        chk("mr_alarm_hour2", 32'(alarm_hour), 32'd0);

        // Gapped delivery of 4,1,2,3: nothing moves until the commit
        frame = '{8'd4, 8'd1, 8'd2, 8'd3};
        foreach (frame[i]) begin
            send_byte(frame[i]);
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk("gap_hold_hour", 32'(alarm_hour), 32'd0);
            chk("gap_hold_en", 32'(alarm_enable), 32'd0);
        end
        @(negedge clk);
        chk("gap_hour", 32'(alarm_hour), 32'd1);
        chk("gap_min", 32'(alarm_min), 32'd2);
        chk("gap_sec", 32'(alarm_sec), 32'd3);
        chk("gap_en", 32'(alarm_enable), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
